// File: rtl/mr_rf_scoreboard_if.sv
// mr_rf_scoreboard_if: decode-side read/alloc and write-back port bundle for the scoreboarded register file.
interface mr_rf_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWB = 1
);
  localparam int RW = $clog2(NREGS);
  logic [NRD-1:0] rd_en;
  logic [NRD*RW-1:0] rd_sel;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic alloc_valid;
  logic [RW-1:0] alloc_reg;
  logic alloc_ready;
  logic [NWB-1:0] wb_valid;
  logic [NWB*RW-1:0] wb_reg;
  logic [NWB*XLEN-1:0] wb_val;
  logic flush;
  logic pend_err;
  modport master (
    output rd_en, rd_sel, alloc_valid, alloc_reg, wb_valid, wb_reg, wb_val, flush,
    input rd_data, rd_busy, alloc_ready, pend_err
  );
  modport slave (
    input rd_en, rd_sel, alloc_valid, alloc_reg, wb_valid, wb_reg, wb_val, flush,
    output rd_data, rd_busy, alloc_ready, pend_err
  );
endinterface

// File: rtl/mr_rf_scoreboard.sv
// mr_rf_scoreboard: register file with per-register pending-write counters, multi-port read/write-back and optional bypass.
module mr_rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWB = 1,
  parameter int PEND_BITS = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  mr_rf_scoreboard_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam logic [PEND_BITS-1:0] PMAX = '1;
  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  logic [NREGS-1:0][PEND_BITS-1:0] pend_q, pend_d;
  logic err_q, err_d, fire;
  int hits, tot, rhits;
  logic [RW-1:0] rsel;
  logic [XLEN-1:0] rdat;
  assign bus.alloc_ready = !rst && (bus.alloc_reg == '0 || pend_q[bus.alloc_reg] != PMAX);
  assign bus.pend_err = err_q;
  assign fire = bus.alloc_valid && bus.alloc_ready && !bus.flush;
  // Each same-cycle write-back hit resolves one pending write when bypassing.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rsel = '0;
    rdat = '0;
    rhits = 0;
    for (int i = 0; i < NRD; i++) begin
      rsel = bus.rd_sel[i*RW +: RW];
      rdat = rf_q[rsel];
      rhits = 0;
      for (int k = 0; k < NWB; k++)
        if (BYPASS != 0 && bus.wb_valid[k] && bus.wb_reg[k*RW +: RW] == rsel && rsel != '0) begin
          rdat = bus.wb_val[k*XLEN +: XLEN];
          rhits++;
        end
      bus.rd_data[i*XLEN +: XLEN] = rdat;
      bus.rd_busy[i] = rst || (bus.rd_en[i] && rsel != '0 && int'(pend_q[rsel]) != rhits);
    end
  end
  // Register 0 is skipped so it stays zero and never pending.
  always_comb begin
    rf_d = rf_q;
    pend_d = pend_q;
    err_d = err_q;
    hits = 0;
    tot = 0;
    for (int r = 1; r < NREGS; r++) begin
      hits = 0;
      for (int k = 0; k < NWB; k++)
        if (bus.wb_valid[k] && bus.wb_reg[k*RW +: RW] == RW'(r)) begin
          rf_d[r] = bus.wb_val[k*XLEN +: XLEN];
          hits++;
        end
      tot = int'(pend_q[r]) + int'(fire && bus.alloc_reg == RW'(r)) - hits;
      pend_d[r] = (bus.flush || tot < 0) ? '0 : PEND_BITS'(tot);
      err_d = err_d || (!bus.flush && tot < 0);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rf_q <= '0;
      pend_q <= '0;
      err_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_mr_rf_scoreboard.sv
// tb_mr_rf_scoreboard: bypass and non-bypass instances driven in lockstep against a behavioural model.
module tb_mr_rf_scoreboard;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWB = 2, PB = 2, RW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [NRD-1:0] rd_en;
  logic [NRD*RW-1:0] rd_sel;
  logic alloc_valid;
  logic [RW-1:0] alloc_reg;
  logic [NWB-1:0] wb_valid;
  logic [NWB*RW-1:0] wb_reg;
  logic [NWB*XLEN-1:0] wb_val;
  logic flush;
  mr_rf_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB)) b1 ();
  mr_rf_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB)) b0 ();
  assign b1.rd_en = rd_en;
  assign b1.rd_sel = rd_sel;
  assign b1.alloc_valid = alloc_valid;
  assign b1.alloc_reg = alloc_reg;
  assign b1.wb_valid = wb_valid;
  assign b1.wb_reg = wb_reg;
  assign b1.wb_val = wb_val;
  assign b1.flush = flush;
  assign b0.rd_en = rd_en;
  assign b0.rd_sel = rd_sel;
  assign b0.alloc_valid = alloc_valid;
  assign b0.alloc_reg = alloc_reg;
  assign b0.wb_valid = wb_valid;
  assign b0.wb_reg = wb_reg;
  assign b0.wb_val = wb_val;
  assign b0.flush = flush;
  mr_rf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB), .PEND_BITS(PB), .BYPASS(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  mr_rf_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB), .PEND_BITS(PB), .BYPASS(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));

  int pend [NREGS];
  logic [XLEN-1:0] rf [NREGS];
  bit err;
  int errors = 0, checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rd_en = '0;
    rd_sel = '0;
    alloc_valid = 1'b0;
    alloc_reg = '0;
    wb_valid = '0;
    wb_reg = '0;
    wb_val = '0;
    flush = 1'b0;
  endtask

  task automatic check_outputs();
    bit rdy, busy;
    logic [XLEN-1:0] d;
    int h, s;
    rdy = !rst && (alloc_reg == 0 || pend[alloc_reg] != (1 << PB) - 1);
    chk("ready_byp1", 64'(b1.alloc_ready), 64'(rdy));
    chk("ready_byp0", 64'(b0.alloc_ready), 64'(rdy));
    chk("err_byp1", 64'(b1.pend_err), 64'(err));
    chk("err_byp0", 64'(b0.pend_err), 64'(err));
    for (int i = 0; i < NRD; i++)
      for (int b = 0; b < 2; b++) begin
        s = int'(rd_sel[i*RW +: RW]);
        d = rf[s];
        h = 0;
        if (b == 1)
          for (int k = 0; k < NWB; k++)
            if (wb_valid[k] && int'(wb_reg[k*RW +: RW]) == s && s != 0) begin
              d = wb_val[k*XLEN +: XLEN];
              h++;
            end
        busy = rst || (rd_en[i] && s != 0 && pend[s] - h != 0);
        chk($sformatf("data%0d_byp%0d", i, b),
            64'(b == 1 ? b1.rd_data[i*XLEN +: XLEN] : b0.rd_data[i*XLEN +: XLEN]), 64'(d));
        chk($sformatf("busy%0d_byp%0d", i, b),
            64'(b == 1 ? b1.rd_busy[i] : b0.rd_busy[i]), 64'(busy));
      end
  endtask

  task automatic settle();
    #4;
    check_outputs();
  endtask

  task automatic tick();
    int n;
    bit fire;
    fire = alloc_valid && !rst && !flush && (alloc_reg == 0 || pend[alloc_reg] != (1 << PB) - 1);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        pend[r] = 0;
        rf[r] = '0;
      end
      err = 1'b0;
    end else
      for (int r = 1; r < NREGS; r++) begin
        n = pend[r] + ((fire && int'(alloc_reg) == r) ? 1 : 0);
        for (int k = 0; k < NWB; k++)
          if (wb_valid[k] && int'(wb_reg[k*RW +: RW]) == r) begin
            rf[r] = wb_val[k*XLEN +: XLEN];
            n--;
          end
        if (flush) pend[r] = 0;
        else if (n < 0) begin
          pend[r] = 0;
          err = 1'b1;
        end else pend[r] = n;
      end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin
      pend[r] = 0;
      rf[r] = '0;
    end
    err = 1'b0;
    clr();
    rst = 1'b1;
    settle();
    chk("rst_busy", 64'(b1.rd_busy), 64'(2'b11));
    chk("rst_ready", 64'(b1.alloc_ready), 64'(0));
    tick();
    cyc();
    rst = 1'b0;
    rd_en = 2'b11;
    rd_sel = {5'd0, 5'd5};
    alloc_reg = 5'd5;
    settle();
    chk("idle_data", 64'(b1.rd_data), 64'(0));
    chk("idle_busy", 64'(b1.rd_busy), 64'(0));
    chk("ready_after_rst", 64'(b1.alloc_ready), 64'(1));
    tick();
    clr(); alloc_valid = 1'b1; alloc_reg = 5'd5; cyc();
    clr(); rd_en = 2'b01; rd_sel[4:0] = 5'd5;
    settle();
    chk("x5_busy", 64'(b1.rd_busy[0]), 64'(1));
    tick();
    wb_valid = 2'b01; wb_reg[4:0] = 5'd5; wb_val[31:0] = 32'hDEADBEEF;
    settle();
    chk("x5_byp_data", 64'(b1.rd_data[31:0]), 64'h0DEADBEEF);
    chk("x5_byp_busy", 64'(b1.rd_busy[0]), 64'(0));
    chk("x5_nobyp_busy", 64'(b0.rd_busy[0]), 64'(1));
    tick();
    wb_valid = '0;
    settle();
    chk("x5_nobyp_data", 64'(b0.rd_data[31:0]), 64'h0DEADBEEF);
    chk("x5_nobyp_free", 64'(b0.rd_busy[0]), 64'(0));
    tick();
    clr(); alloc_valid = 1'b1; alloc_reg = 5'd7;
    repeat (3) cyc();
    alloc_valid = 1'b0; alloc_reg = 5'd8;
    settle();
    chk("x8_ready", 64'(b1.alloc_ready), 64'(1));
    tick();
    alloc_valid = 1'b1; alloc_reg = 5'd7; wb_valid = 2'b01; wb_reg[4:0] = 5'd7; wb_val[31:0] = 32'h77;
    settle();
    chk("x7_sat", 64'(b1.alloc_ready), 64'(0));
    tick();
    clr(); alloc_reg = 5'd7;
    settle();
    chk("x7_ready_again", 64'(b1.alloc_ready), 64'(1));
    tick();
    clr(); alloc_valid = 1'b1; alloc_reg = 5'd3; cyc();
    wb_valid = 2'b01; wb_reg[4:0] = 5'd3; wb_val[31:0] = 32'h33; cyc();
    clr(); rd_en = 2'b10; rd_sel[9:5] = 5'd3;
    settle();
    chk("x3_busy", 64'(b1.rd_busy[1]), 64'(1));
    chk("x3_data", 64'(b0.rd_data[63:32]), 64'h33);
    tick();
    clr(); alloc_valid = 1'b1; alloc_reg = 5'd9; repeat (2) cyc();
    clr(); rd_en = 2'b01; rd_sel[4:0] = 5'd9;
    wb_valid = 2'b11; wb_reg = {5'd9, 5'd9}; wb_val = {32'h222, 32'h111};
    settle();
    chk("x9_byp_data", 64'(b1.rd_data[31:0]), 64'h222);
    chk("x9_byp_busy", 64'(b1.rd_busy[0]), 64'(0));
    tick();
    wb_valid = '0;
    settle();
    chk("x9_data", 64'(b0.rd_data[31:0]), 64'h222);
    chk("x9_free", 64'(b0.rd_busy[0]), 64'(0));
    tick();
    clr(); wb_valid = 2'b01; wb_reg[4:0] = 5'd10; cyc();
    clr();
    settle();
    chk("underflow_err", 64'(b1.pend_err), 64'(1));
    tick();
    flush = 1'b1; cyc();
    clr();
    settle();
    chk("err_sticky", 64'(b1.pend_err), 64'(1));
    tick();
    rst = 1'b1; cyc();
    rst = 1'b0;
    settle();
    chk("err_cleared", 64'(b1.pend_err), 64'(0));
    tick();
    alloc_valid = 1'b1; alloc_reg = 5'd4; cyc();
    alloc_reg = 5'd6; cyc();
    alloc_reg = 5'd11; flush = 1'b1; cyc();
    clr(); rd_en = 2'b11; rd_sel = {5'd11, 5'd4};
    settle();
    chk("flush_busy", 64'(b1.rd_busy), 64'(0));
    tick();
    rd_sel = {5'd6, 5'd6}; cyc();
    clr(); alloc_valid = 1'b1; alloc_reg = 5'd0; wb_valid = 2'b01; wb_val[31:0] = 32'hFFFF; cyc();
    clr(); rd_en = 2'b01;
    settle();
    chk("x0_data", 64'(b1.rd_data[31:0]), 64'(0));
    chk("x0_err", 64'(b1.pend_err), 64'(0));
    tick();
    repeat (1500) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 31) == 0);
      rd_en = NRD'($urandom);
      for (int i = 0; i < NRD; i++) rd_sel[i*RW +: RW] = RW'($urandom_range(0, 7));
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_reg = RW'($urandom_range(0, 7));
      for (int k = 0; k < NWB; k++) begin
        wb_valid[k] = ($urandom_range(0, 3) == 0);
        wb_reg[k*RW +: RW] = RW'($urandom_range(0, 7));
        wb_val[k*XLEN +: XLEN] = $urandom;
      end
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mr_rf_scoreboard.md
Name: mr_rf_scoreboard

Overview:
Parametrised integer register file with a per-register pending-write scoreboard, multiple read ports, multiple write-back ports and optional write-back bypass. It sits between the decode stage (operand reads, destination allocation) and write-back (register commits). It is the shared source of operand data and RAW-hazard status for single-issue and future multi-port pipelines.

Parameters:
XLEN, 32, register data width
NREGS, 32, architectural register count (16 for RV32E); index width RW = $clog2(NREGS)
NRD, 2, number of read ports
NWB, 1, number of write-back ports
PEND_BITS, 2, width of each pending-write counter (max 2^PEND_BITS-1 in flight per register)
BYPASS, 1, 1 = same-cycle write-back value forwarded to read ports; 0 = no forwarding

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_en  in  NRD  read port i is in use this cycle
rd_sel  in  NRD*RW  read register index per port
rd_data  out  NRD*XLEN  read data per port (combinational)
rd_busy  out  NRD  read port i has an unresolved RAW hazard
alloc_valid  in  1  decode issues an instruction that writes alloc_reg
alloc_reg  in  RW  destination register being allocated
alloc_ready  out  1  allocation accepted when high together with alloc_valid
wb_valid  in  NWB  write-back port k valid
wb_reg  in  NWB*RW  write-back destination per port
wb_val  in  NWB*XLEN  write-back data per port
flush  in  1  clear all pending counters (pipeline squash)
pend_err  out  1  sticky error: write-back to a register with no pending write

Behaviour:
- Register 0 reads as 0, is never busy, and is never written. Allocations and write-backs to register 0 are accepted and have no effect.
- Reset (rst high at a clk edge): all registers are 0, all pending counters are 0, and pend_err is 0 on the next cycle. While rst is high, alloc_ready=0 and rd_busy is all 1s, so decode stalls.
- Read (combinational, 0-cycle latency):
  - rd_data[i] = regfile[rd_sel[i]].
  - If BYPASS=1 and any wb_valid[k] has wb_reg[k]==rd_sel[i]!=0, rd_data[i] = wb_val of the highest such k.
- rd_busy[i] = rd_en[i] & rd_sel[i]!=0 & (eff != 0).
  - BYPASS=1: eff = pend[rd_sel[i]] minus the number of same-cycle wb hits on that register.
  - BYPASS=0: eff = pend[rd_sel[i]].
  - A same-cycle allocation never affects rd_busy, because the allocating instruction reads before it writes.
  - rd_en[i]=0 gives rd_busy[i]=0; rd_data is still driven.
- Allocation:
  - alloc_ready = !rst & (alloc_reg==0 | pend[alloc_reg] != 2^PEND_BITS-1). Saturation blocks allocation even if a wb to the same register occurs that cycle.
  - Fire = alloc_valid & alloc_ready.
- Counter update per register r!=0, each clk edge:
  - pend_next = pend + (fire & alloc_reg==r) − (number of wb ports with wb_valid & wb_reg==r).
  - Simultaneous alloc and wb to the same register leave the count unchanged.
- Write-back data: regfile[wb_reg[k]] <= wb_val[k] for every valid k. Several ports targeting the same register in one cycle: the highest k wins, and each port decrements.
- Underflow: a wb to r where (pend + alloc inc) < number of wb hits.
  - Data is still written, the counter clamps at 0, and pend_err is set.
  - pend_err stays set until rst.
- flush: all counters become 0 next cycle.
  - Same-cycle wb still writes data and raises no pend_err.
  - Same-cycle alloc is ignored, regardless of alloc_ready.
  - The regfile is untouched.
- rst overrides flush, alloc and wb. Reset mid-operation discards all in-flight pending state.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rd_data=0, rd_busy=0; alloc_ready=1 one cycle after rst falls.
- Alloc x5; next cycle read x5 -> rd_busy=1. wb x5=0xDEADBEEF with BYPASS=1 -> same cycle rd_data=0xDEADBEEF, rd_busy=0. Next cycle pend=0. Repeat with BYPASS=0 -> busy in the wb cycle, data 0xDEADBEEF one cycle later.
- PEND_BITS=2: alloc x7 three times -> alloc_ready=0 for x7, while x8 still has alloc_ready=1. A wb to x7 in the same cycle as alloc_valid (blocked) -> count goes 3->2 and alloc_ready=1 next cycle.
- Simultaneous alloc x3 and wb x3 (pend=1) -> pend stays 1, regfile[x3] updated, rd_busy for x3 stays 1.
- NWB=2: wb0 and wb1 both target x9 with pend=2 -> x9 holds wb1 value, pend=0. A wb to x10 with pend=0 -> pend_err=1 and stays set through flush; cleared only by rst.
- Alloc x4, x6; flush with alloc x11 in the same cycle -> all rd_busy=0 next cycle, x11 not pending; alloc/wb to x0 -> no state change, no pend_err.
